// File: rtl/pipibibs_video_pkg.sv
// rtl/pipibibs_video_pkg.sv - shared raster timing constants, offset type and sync window helper
//
// Purpose:
//   Default 432x262 raster constants used as parameter defaults by the timing
//   generator, the counter width, the signed 4-bit sync offset type and a
//   helper that tests a position against an offset-shifted half-open window.
// Ports: none (package).
package pipibibs_video_pkg;

    localparam int CNTW     = 9;

    localparam int H_TOTAL  = 432;
    localparam int H_ACTIVE = 320;
    localparam int HS_START = 352;
    localparam int HS_END   = 384;

    localparam int V_TOTAL  = 262;
    localparam int V_ACTIVE = 240;
    localparam int VS_START = 248;
    localparam int VS_END   = 251;

    typedef logic signed [3:0] offset_t;

    // True when pos lies in [start+off, stop+off). The window is evaluated one
    // bit wider than the counter and signed, so a negative offset near zero or
    // a positive offset near the top of the range never wraps around.
    function automatic logic in_window(
        input logic [CNTW-1:0] pos,
        input logic [CNTW-1:0] start,
        input logic [CNTW-1:0] stop,
        input offset_t         off
    );
        logic signed [CNTW:0] p;
        logic signed [CNTW:0] off_x;
        logic signed [CNTW:0] lo;
        logic signed [CNTW:0] hi;
        p     = $signed({1'b0, pos});
        off_x = $signed({{(CNTW-3){off[3]}}, off});
        lo    = $signed({1'b0, start}) + off_x;
        hi    = $signed({1'b0, stop}) + off_x;
        return (p >= lo) && (p < hi);
    endfunction

endpackage

// File: rtl/pipibibs_wrap_cnt.sv
// rtl/pipibibs_wrap_cnt.sv - enable-gated modulo-N counter with wrap indication
//
// Purpose:
//   Counts 0..N-1 on clock edges where en=1 and holds otherwise. Exposes the
//   value the counter will take on the coming edge so the parent can register
//   decoded flags in the same cycle as the count itself.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset, clears the count
//   en       in   advance enable
//   cnt      out  current count
//   cnt_nxt  out  count after the coming edge (combinational)
//   wrap     out  coming edge wraps N-1 -> 0 (combinational, en qualified)
module pipibibs_wrap_cnt #(
    parameter int N = 432,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         wrap
);

    always_comb begin
        wrap    = en && (cnt == W'(N - 1));
        cnt_nxt = cnt;
        if (en) begin
            cnt_nxt = wrap ? '0 : cnt + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/pipibibs_video_timing.sv
// rtl/pipibibs_video_timing.sv - raster timing generator: counters, blank, sync, frame, vblank irq
//
// Purpose:
//   Runs in the CLK96 domain and advances one pixel per CEN675 pulse. Produces
//   the H/V counters and zero-skew registered blank/sync flags, a line start
//   pulse, a frame toggle and the 68k vblank interrupt request.
// Ports:
//   CLK96    in   core clock
//   RESET96  in   asynchronous active-high reset
//   CEN675   in   pixel enable
//   HOFFSET  in   signed horizontal sync shift, sampled at frame start
//   VOFFSET  in   signed vertical sync shift, sampled at frame start
//   INT_ACK  in   interrupt acknowledge level, clears VINT
//   HCNT     out  pixel counter
//   VCNT     out  line counter
//   HBLANK   out  horizontal blank
//   VBLANK   out  vertical blank
//   HSYNC    out  horizontal sync
//   VSYNC    out  vertical sync
//   LINE_ST  out  one-cycle pulse after the HCNT wrap edge
//   FRAME    out  toggles on the VCNT wrap edge
//   VINT     out  vblank interrupt request
module pipibibs_video_timing #(
    parameter int H_TOTAL  = pipibibs_video_pkg::H_TOTAL,
    parameter int H_ACTIVE = pipibibs_video_pkg::H_ACTIVE,
    parameter int HS_START = pipibibs_video_pkg::HS_START,
    parameter int HS_END   = pipibibs_video_pkg::HS_END,
    parameter int V_TOTAL  = pipibibs_video_pkg::V_TOTAL,
    parameter int V_ACTIVE = pipibibs_video_pkg::V_ACTIVE,
    parameter int VS_START = pipibibs_video_pkg::VS_START,
    parameter int VS_END   = pipibibs_video_pkg::VS_END
) (
    input  logic                                CLK96,
    input  logic                                RESET96,
    input  logic                                CEN675,
    input  logic [3:0]                          HOFFSET,
    input  logic [3:0]                          VOFFSET,
    input  logic                                INT_ACK,
    output logic [pipibibs_video_pkg::CNTW-1:0] HCNT,
    output logic [pipibibs_video_pkg::CNTW-1:0] VCNT,
    output logic                                HBLANK,
    output logic                                VBLANK,
    output logic                                HSYNC,
    output logic                                VSYNC,
    output logic                                LINE_ST,
    output logic                                FRAME,
    output logic                                VINT
);

    import pipibibs_video_pkg::*;

    logic [CNTW-1:0] hcnt_nxt;
    logic [CNTW-1:0] vcnt_nxt;
    logic            h_wrap;
    logic            v_wrap;
    logic            vint_set;
    offset_t         hoff_q;
    offset_t         voff_q;
    offset_t         hoff_eff;
    offset_t         voff_eff;

    pipibibs_wrap_cnt #(
        .N (H_TOTAL),
        .W (CNTW)
    ) u_hcnt (
        .clk     (CLK96),
        .rst     (RESET96),
        .en      (CEN675),
        .cnt     (HCNT),
        .cnt_nxt (hcnt_nxt),
        .wrap    (h_wrap)
    );

    // The line counter only moves on the pixel edge that ends a line, so its
    // wrap already implies CEN675 and marks the first pixel of a new frame.
    pipibibs_wrap_cnt #(
        .N (V_TOTAL),
        .W (CNTW)
    ) u_vcnt (
        .clk     (CLK96),
        .rst     (RESET96),
        .en      (h_wrap),
        .cnt     (VCNT),
        .cnt_nxt (vcnt_nxt),
        .wrap    (v_wrap)
    );

    // Pixel (0,0) of a new frame already belongs to that frame, so on the
    // frame wrap edge the freshly sampled offsets drive the sync decode.
    always_comb begin
        hoff_eff = v_wrap ? offset_t'(HOFFSET) : hoff_q;
        voff_eff = v_wrap ? offset_t'(VOFFSET) : voff_q;
    end

    assign vint_set = h_wrap && (vcnt_nxt == CNTW'(V_ACTIVE));

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            hoff_q  <= '0;
            voff_q  <= '0;
            HBLANK  <= 1'b0;
            VBLANK  <= 1'b0;
            HSYNC   <= 1'b0;
            VSYNC   <= 1'b0;
            LINE_ST <= 1'b0;
            FRAME   <= 1'b0;
            VINT    <= 1'b0;
        end else begin
            LINE_ST <= h_wrap;

            if (v_wrap) begin
                hoff_q <= offset_t'(HOFFSET);
                voff_q <= offset_t'(VOFFSET);
                FRAME  <= ~FRAME;
            end

            // Flags are decoded from the next count so they land on the same
            // edge as the counters they describe.
            if (CEN675) begin
                HBLANK <= (hcnt_nxt >= CNTW'(H_ACTIVE));
                VBLANK <= (vcnt_nxt >= CNTW'(V_ACTIVE));
                HSYNC  <= in_window(hcnt_nxt, CNTW'(HS_START), CNTW'(HS_END), hoff_eff);
                VSYNC  <= in_window(vcnt_nxt, CNTW'(VS_START), CNTW'(VS_END), voff_eff);
            end

            // A new request beats an acknowledge seen on the same edge, so an
            // acknowledge left high from the previous frame cannot swallow it.
            if (vint_set) begin
                VINT <= 1'b1;
            end else if (INT_ACK) begin
                VINT <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipibibs_video_timing.sv
// tb/tb_pipibibs_video_timing.sv - scoreboard bench for pipibibs_video_timing
module tb_pipibibs_video_timing;

    localparam int HT  = 48;
    localparam int HA  = 32;
    localparam int HSS = 36;
    localparam int HSE = 40;
    localparam int VT  = 24;
    localparam int VA  = 16;
    localparam int VSS = 18;
    localparam int VSE = 20;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       cen  = 1'b0;
    logic       ack  = 1'b0;
    logic [3:0] hoff = 4'd0;
    logic [3:0] voff = 4'd0;
    logic [8:0] hcnt;
    logic [8:0] vcnt;
    logic       hblank, vblank, hsync, vsync, line_st, frame, vint;

    pipibibs_video_timing #(
        .H_TOTAL (HT), .H_ACTIVE (HA), .HS_START (HSS), .HS_END (HSE),
        .V_TOTAL (VT), .V_ACTIVE (VA), .VS_START (VSS), .VS_END (VSE)
    ) dut (
        .CLK96   (clk),
        .RESET96 (rst),
        .CEN675  (cen),
        .HOFFSET (hoff),
        .VOFFSET (voff),
        .INT_ACK (ack),
        .HCNT    (hcnt),
        .VCNT    (vcnt),
        .HBLANK  (hblank),
        .VBLANK  (vblank),
        .HSYNC   (hsync),
        .VSYNC   (vsync),
        .LINE_ST (line_st),
        .FRAME   (frame),
        .VINT    (vint)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] h;
        logic [8:0] v;
        logic       hb;
        logic       vb;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fr;
        logic       vi;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: everything follows from the number of enables since
    // reset, plus the offsets captured at the start of the current frame.
    int m_n    = 0;
    int m_hoff = 0;
    int m_voff = 0;
    bit m_vint = 1'b0;
    bit m_ls   = 1'b0;

    function automatic obs_t model_obs();
        obs_t o;
        int   h, l, v;
        h    = m_n % HT;
        l    = m_n / HT;
        v    = l % VT;
        o.h  = 9'(h);
        o.v  = 9'(v);
        o.hb = (h >= HA);
        o.vb = (v >= VA);
        o.hs = (h >= HSS + m_hoff) && (h < HSE + m_hoff);
        o.vs = (v >= VSS + m_voff) && (v < VSE + m_voff);
        o.ls = m_ls;
        o.fr = ((l / VT) % 2) == 1;
        o.vi = m_vint;
        return o;
    endfunction

    task automatic check_zero();
        n_cmp++;
        if ({hcnt, vcnt, hblank, vblank, hsync, vsync, line_st, frame, vint} !== 25'd0) begin
            n_err++;
            $display("FAIL reset_async t=%0t got h=%0d v=%0d flags=%b required all zero",
                     $time, hcnt, vcnt, {hblank, vblank, hsync, vsync, line_st, frame, vint});
        end
    endtask

    // Called right after a falling edge: applies inputs for the next rising
    // edge, advances the model and queues what the DUT must then show.
    task automatic drive(input bit r, input bit e, input bit a);
        bit set;
        int l;
        rst = r;
        cen = e;
        ack = a;
        if (r) begin
            m_n = 0; m_hoff = 0; m_voff = 0; m_vint = 1'b0; m_ls = 1'b0;
        end else begin
            set  = 1'b0;
            m_ls = 1'b0;
            if (e) begin
                m_n++;
                if (m_n % HT == 0) begin
                    m_ls = 1'b1;
                    l    = m_n / HT;
                    if (l % VT == 0) begin
                        m_hoff = int'($signed(hoff));
                        m_voff = int'($signed(voff));
                    end
                    if (l % VT == VA) set = 1'b1;
                end
            end
            if (set) m_vint = 1'b1;
            else if (a) m_vint = 1'b0;
        end
        exp_q.push_back(model_obs());
        if (r) begin
            #1;
            check_zero();
        end
        @(negedge clk);
    endtask

    // Monitor: one expectation per rising edge, sampled just after it.
    initial begin
        obs_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {hcnt, vcnt, hblank, vblank, hsync, vsync, line_st, frame, vint};
                n_cmp++;
                if (g !== e) begin
                    n_err++;
                    $display("FAIL scoreboard t=%0t got h=%0d v=%0d hb,vb,hs,vs,ls,fr,vi=%b required h=%0d v=%0d hb,vb,hs,vs,ls,fr,vi=%b",
                             $time, g.h, g.v, g[6:0], e.h, e.v, e[6:0]);
                end
            end
        end
    end

    initial begin
        int  since_rise;
        bit  prev_vint;
        bit  e, a, found;
        int  cur_h, cur_v, cur_f;
        bit  moved;

        @(negedge clk);
        repeat (4) drive(1'b1, 1'b0, 1'b0);

        // No enables at all: everything holds at reset values.
        repeat (1000) drive(1'b0, 1'b0, 1'b0);

        // Nominal cadence, one enable every 14 cycles.
        for (int i = 0; i < 200 * 14; i++) drive(1'b0, (i % 14) == 13, 1'b0);

        // Dense random enables with offset changes and interrupt handshakes.
        since_rise = -1;
        moved      = 1'b0;
        for (int c = 0; c < 12000; c++) begin
            cur_h = m_n % HT;
            cur_v = (m_n / HT) % VT;
            cur_f = m_n / (HT * VT);
            e = ($urandom_range(3) != 0);
            if (!moved && cur_v == 5) begin
                hoff  = 4'h8;
                moved = 1'b1;
            end
            if (cur_f >= 4 && $urandom_range(299) == 0) begin
                hoff = 4'($urandom);
                voff = 4'($urandom);
            end
            if (cur_f % 2 == 0) begin
                a = (since_rise == 5);
            end else begin
                a = (cur_v == VA - 1 && cur_h >= HT - 4) || (since_rise >= 0 && since_rise < 3);
            end
            if ($urandom_range(199) == 0) a = 1'b1;
            prev_vint = m_vint;
            drive(1'b0, e, a);
            if (m_vint && !prev_vint) since_rise = 0;
            else if (since_rise >= 0 && since_rise < 20) since_rise++;
            else since_rise = -1;
        end

        // Reset in the middle of a line, then restart counting.
        hoff  = 4'd0;
        voff  = 4'd0;
        found = 1'b0;
        for (int i = 0; i < 2 * HT * VT && !found; i++) begin
            if (m_n % HT == 20 && (m_n / HT) % VT == 10) found = 1'b1;
            else drive(1'b0, 1'b1, 1'b0);
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL reach_mid_line got=not_reached required=h20_v10");
        end
        repeat (3) drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        repeat (HT + 5) drive(1'b0, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain got=%0d required=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
